// File: rtl/addsub_seq_unit.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB-first, registered carry chain.
// Optional result saturation on signed overflow is built when ADDSUB_SAT_EN is defined.
module addsub_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       fsm_state
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  work;
    logic              carry_q;
    logic [CW-1:0]     cnt;

    logic [CHUNK:0]    chunk_sum;
    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  final_res;
    logic              ovf;
    logic              last;

    assign fsm_state = state;
    assign last      = (cnt == CW'(N - 1));

    // raw is the full word as it will look once the current chunk is written.
    always_comb begin
        chunk_sum = {1'b0, a_q[int'(cnt) * CHUNK +: CHUNK]}
                  + {1'b0, b_q[int'(cnt) * CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        raw = work;
        raw[int'(cnt) * CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        if (ovf)
            final_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        else
            final_res = raw;
`else
        final_res = raw;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            work      <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    work    <= raw;
                    carry_q <= chunk_sum[CHUNK];
                    if (last) begin
                        result    <= final_res;
                        carry_out <= chunk_sum[CHUNK];
                        overflow  <= ovf;
                        zero      <= (final_res == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // IDLE and DONE both accept a new request; DONE gives back-to-back issue.
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= mode ? ~b : b;
                        carry_q <= carry_in;
                        work    <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq_unit.sv
// Directed bench for addsub_seq_unit: default 8-bit chunks plus a single-chunk instance.
// Expectations follow ADDSUB_SAT_EN when it is defined for the build.
module tb_addsub_seq_unit;

    logic        clk;
    logic        reset;

    logic        start;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;
    logic [1:0]  fsm_state;

    logic        start1;
    logic        mode1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        carry_in1;
    logic        busy1;
    logic        done1;
    logic [31:0] result1;
    logic        carry_out1;
    logic        overflow1;
    logic        zero1;
    logic [1:0]  fsm_state1;

    int total;
    int passed;
    int fails;
    int n;

    addsub_seq_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero), .fsm_state(fsm_state)
    );

    addsub_seq_unit #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode1), .a(a1), .b(b1),
        .carry_in(carry_in1), .busy(busy1), .done(done1), .result(result1),
        .carry_out(carry_out1), .overflow(overflow1), .zero(zero1), .fsm_state(fsm_state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request on the 8-bit-chunk instance and returns the edges until done.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          input logic im, input logic ic, output int edges);
        a = ia; b = ib; mode = im; carry_in = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic check_flags(input string tag, input logic [31:0] er,
                               input logic ec, input logic eo, input logic ez);
        check({tag, "_result"}, result, er);
        check({tag, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        reset = 1'b1;
        start = 1'b0; mode = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        start1 = 1'b0; mode1 = 1'b0; a1 = '0; b1 = '0; carry_in1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, 32'd0);
        check_flags("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // 5 + 3
        run_op(32'h5, 32'h3, 1'b0, 1'b0, n);
        check("add_latency", n, 4);
        check("add_done", {31'd0, done}, 32'd1);
        check("add_busy", {31'd0, busy}, 32'd0);
        check_flags("add", 32'h8, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("add_done_once", {31'd0, done}, 32'd0);
        check("add_hold", result, 32'h8);

        // 5 - 5
        run_op(32'h5, 32'h5, 1'b1, 1'b1, n);
        check("sub0_latency", n, 4);
        check_flags("sub0", 32'h0, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;

        // 0x7FFFFFFF + 1
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, n);
`ifdef ADDSUB_SAT_EN
        check_flags("povf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
`else
        check_flags("povf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
`endif
        @(posedge clk); #1;

        // 0x80000000 - 1
        run_op(32'h8000_0000, 32'h1, 1'b1, 1'b1, n);
`ifdef ADDSUB_SAT_EN
        check_flags("novf", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`else
        check_flags("novf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
`endif
        @(posedge clk); #1;

        // Carry ripples across every chunk boundary.
        run_op(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, n);
        check_flags("ripple", 32'h0100_0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Starts while busy are ignored; start in DONE is accepted.
        a = 32'h1; b = 32'h1; mode = 1'b0; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_held_during_run", result, 32'h0100_0000);
        a = 32'h9; b = 32'h9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 2;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ign_latency", n, 4);
        check("ign_result", result, 32'h2);
        a = 32'h9; b = 32'h9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accept_busy", {31'd0, busy}, 32'd1);
        check("b2b_accept_done", {31'd0, done}, 32'd0);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_latency", n, 4);
        check("b2b_result", result, 32'h12);

        // Asynchronous reset mid-RUN.
        a = 32'h3; b = 32'h4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check_flags("arst", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("arst_no_done", n, 0);
        check("arst_idle_state", {30'd0, fsm_state}, 32'd0);

        // Single-chunk instance: 0xFFFFFFFF + 1
        a1 = 32'hFFFF_FFFF; b1 = 32'h1; mode1 = 1'b0; carry_in1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("n1_busy", {31'd0, busy1}, 32'd1);
        n = 0;
        while (!done1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("n1_latency", n, 1);
        check("n1_result", result1, 32'h0);
        check("n1_carry", {31'd0, carry_out1}, 32'd1);
        check("n1_zero", {31'd0, zero1}, 32'd1);
        check("n1_ovf", {31'd0, overflow1}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/addsub_seq_unit.md
# addsub_seq_unit

Parametrised multi-cycle adder/subtractor for the datapath. It computes `a + b + carry_in` or `a + ~b + carry_in` over WIDTH bits, processing CHUNK bits per clock with a registered carry chain. It has a start/done handshake and registered result and flags. It generalises the fixed 32-bit combinational subtractor into a sequential add/sub unit for the ALU and address paths, trading latency for a short carry chain.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle. N = WIDTH/CHUNK cycles per operation.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- mode  in  1  0 = add (`a + b + carry_in`); 1 = subtract (`a + ~b + carry_in`). The caller drives carry_in=1 for two's-complement a−b.
- a, b  in  WIDTH  operands; captured on the accepting edge.
- carry_in  in  1  carry into bit 0; captured with the operands.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result and flags are valid.
- result  out  WIDTH  sum or difference; held until the next accepted start.
- carry_out  out  1  raw carry out of bit WIDTH−1.
- overflow  out  1  signed overflow.
- zero  out  1  result == 0, evaluated after any saturation.

## Operation
- FSM states:
  - IDLE: busy=0, done=0. When start=1, latch a, the effective b (b, or ~b when mode=1), and carry_in; clear the chunk counter; go to RUN.
  - RUN: busy=1. Each edge adds chunk[cnt] of a and of effective b plus the registered carry, writes result chunk[cnt], and updates the carry register. After chunk N−1, go to DONE.
  - DONE: done=1, busy=0, all outputs valid. If start=1 in this cycle, accept new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- start while busy=1 is ignored. Operands are not re-sampled.
- Chunk order is LSB-first. The counter width is clog2(N), minimum 1 bit. The counter wraps only through restart; it never free-runs.
- Flags are computed once at the RUN→DONE transition:
  - overflow = (a[W−1] == effb[W−1]) && (raw_result[W−1] != a[W−1]).
  - carry_out is the final chunk carry.
  - zero uses the final result.
- result, carry_out, overflow and zero keep their values through IDLE until the next completion. They are not cleared on start.
- Reset, asynchronous at any time including mid-RUN:
  - State goes to IDLE.
  - result=0, carry_out=0, overflow=0, zero=0, busy=0, done=0.
  - The in-flight operation is discarded and no done pulse is issued.

## Timing
- Edge E0 samples start=1 in IDLE. busy=1 for the N cycles after E0.
- The cycle after edge E0+N is DONE: done=1, busy=0, outputs valid.
- Latency from the start edge to the done cycle is N+1 edges (5 for the defaults).
- Back-to-back throughput is one operation per N+1 cycles.
- CHUNK=WIDTH gives N=1: one RUN cycle, then DONE.
- done is registered: it is high for exactly one cycle per accepted operation and is never asserted twice for one operation.

## Configuration
- Macro `ADDSUB_SAT_EN`.
- Defined: on signed overflow, result is clamped.
  - Positive overflow (a[W−1]=0) gives 0x7F..F.
  - Negative overflow gives 0x80..0.
  - overflow is still reported. zero is evaluated on the clamped value.
- Undefined: result wraps modulo 2^WIDTH and no clamping logic is built.
- carry_out is unaffected in both builds.

## Test plan
All tests use WIDTH=32, CHUNK=8 unless stated.
1. Add a=0x0000_0005, b=0x0000_0003, carry_in=0, mode=0 → done in the 5th cycle after the start edge; result=0x0000_0008, carry_out=0, overflow=0, zero=0.
2. Sub a=0x0000_0005, b=0x0000_0005, mode=1, carry_in=1 → result=0x0000_0000, zero=1, carry_out=1, overflow=0.
3. Add a=0x7FFF_FFFF, b=0x0000_0001 → overflow=1.
   - Without ADDSUB_SAT_EN: result=0x8000_0000.
   - With ADDSUB_SAT_EN: result=0x7FFF_FFFF.
4. Sub a=0x8000_0000, b=0x0000_0001, carry_in=1 → overflow=1, carry_out=1.
   - Without ADDSUB_SAT_EN: result=0x7FFF_FFFF.
   - With ADDSUB_SAT_EN: result=0x8000_0000.
5. Two starts while busy, then a start in the DONE cycle:
   - Pulse start with operands 1+1. Pulse start again in cycles 2 and 3 with 9+9 → the cycles 2 and 3 starts are ignored; the first done gives result=2.
   - start=1 in the DONE cycle with 9+9 → accepted; result=0x12 five cycles later.
   - Then assert reset during RUN → busy=0, all outputs 0 immediately (asynchronously), no done pulse.
6. CHUNK=32, add a=0xFFFF_FFFF, b=0x0000_0001 → done on the 2nd cycle after the start edge; result=0, carry_out=1, zero=1, overflow=0.
